// File: rtl/imm_instr_encoder_pkg.sv
// Shared immediate-format definitions for the immediate encoder and the decode-stage generator.
package imm_instr_encoder_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned IMM_TYPE_W = 3;

    // RV32I immediate formats; encodings 5-7 are illegal.
    typedef enum logic [IMM_TYPE_W-1:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_t;

    // One encode request as held in the first pipeline stage.
    typedef struct packed {
        logic [IMM_TYPE_W-1:0] imm_type;
        logic [INSTR_W-1:0]    imm_val;
        logic [INSTR_W-1:0]    base_instr;
    } enc_req_t;

    // True when val is the sign extension of val[msb:0] (all bits above msb equal bit msb).
    function automatic logic fits_signed(input logic [INSTR_W-1:0] val, input int unsigned msb);
        logic [INSTR_W-1:0] upper;
        upper = INSTR_W'($signed(val) >>> msb);
        return (upper == '0) || (upper == '1);
    endfunction

endpackage

// File: rtl/imm_instr_encoder_imm_pack.sv
// Combinational immediate scatter: places an immediate into its RV32I field positions and flags
// values that the chosen format cannot represent.
module imm_pack
    import imm_instr_encoder_pkg::*;
(
    input  logic [IMM_TYPE_W-1:0] imm_type,
    input  logic [INSTR_W-1:0]    imm_val,
    input  logic [INSTR_W-1:0]    base_instr,
    output logic [INSTR_W-1:0]    word,
    output logic                  err
);

    // Field scatter and representability check per format; the word is always produced.
    always_comb begin
        word = base_instr;
        err  = 1'b1;
        case (imm_type)
            IMM_I: begin
                word = {imm_val[11:0], base_instr[19:0]};
                err  = !fits_signed(imm_val, 11);
            end
            IMM_S: begin
                word = {imm_val[11:5], base_instr[24:12], imm_val[4:0], base_instr[6:0]};
                err  = !fits_signed(imm_val, 11);
            end
            IMM_B: begin
                word = {imm_val[12], imm_val[10:5], base_instr[24:12],
                        imm_val[4:1], imm_val[11], base_instr[6:0]};
                err  = !fits_signed(imm_val, 12) || imm_val[0];
            end
            IMM_U: begin
                word = {imm_val[31:12], base_instr[11:0]};
                err  = |imm_val[11:0];
            end
            IMM_J: begin
                word = {imm_val[20], imm_val[10:1], imm_val[11], imm_val[19:12], base_instr[11:0]};
                err  = !fits_signed(imm_val, 20) || imm_val[0];
            end
            default: begin
                word = base_instr;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_instr_encoder.sv
// Two-stage valid/ready immediate encoder: S1 holds the request, S2 holds the packed word and
// its error flag. Also keeps a saturating count of errored words handed downstream.
module imm_instr_encoder
    import imm_instr_encoder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ERR_CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IMM_TYPE_W-1:0] imm_type,
    input  logic [DATA_WIDTH-1:0] imm_val,
    input  logic [DATA_WIDTH-1:0] base_instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic                  out_err,
    input  logic                  err_clr,
    output logic [ERR_CNT_W-1:0]  err_count
);

    enc_req_t              s1_req;
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] pack_word;
    logic                  pack_err;
    logic                  s1_load_c;
    logic                  s2_load_c;
    logic                  err_inc_c;

    // Ready chain: S2 takes S1 when it is empty or draining; S1 takes input when empty or moving on.
    assign s2_load_c = s1_valid && (!out_valid || out_ready);
    assign in_ready  = !s1_valid || s2_load_c;
    assign s1_load_c = in_valid && in_ready;
    assign err_inc_c = out_valid && out_ready && out_err;

    // Stage 1: capture the raw request.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_req   <= '0;
        end else if (s1_load_c) begin
            s1_valid <= 1'b1;
            s1_req   <= '{imm_type: imm_type, imm_val: imm_val, base_instr: base_instr};
        end else if (s2_load_c) begin
            s1_valid <= 1'b0;
        end
    end

    imm_pack u_imm_pack (
        .imm_type   (s1_req.imm_type),
        .imm_val    (s1_req.imm_val),
        .base_instr (s1_req.base_instr),
        .word       (pack_word),
        .err        (pack_err)
    );

    // Stage 2: register the packed word; hold it while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            instr_out <= '0;
            out_err   <= 1'b0;
        end else if (s2_load_c) begin
            out_valid <= 1'b1;
            instr_out <= pack_word;
            out_err   <= pack_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating errored-handoff counter; clear takes priority over increment.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_count <= '0;
        end else if (err_inc_c && !(&err_count)) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Randomized self-checking bench for imm_instr_encoder with an arithmetic reference model.
module tb_imm_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  imm_type;
    logic [31:0] imm_val;
    logic [31:0] base_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_out;
    logic        out_err;
    logic        err_clr;
    logic [15:0] err_count;

    typedef struct {
        logic [31:0] word;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          accepted  = 0;
    int          handoffs  = 0;
    int          model_cnt = 0;
    logic [31:0] last_word = '0;
    logic        last_err  = 1'b0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_word = '0;
    logic        prev_err  = 1'b0;
    logic        exp_ov;
    bit          rand_mode = 0;

    imm_instr_encoder #(.DATA_WIDTH(32), .ERR_CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imm_type   (imm_type),
        .imm_val    (imm_val),
        .base_instr (base_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .instr_out  (instr_out),
        .out_err    (out_err),
        .err_clr    (err_clr),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: masks and shifts straight from the format tables, ranges as signed integers.
    function automatic exp_t model(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] base);
        exp_t   r;
        longint v;
        v     = longint'($signed(imm));
        r.acc = 0;
        case (t)
            3'd0: begin
                r.word = (base & 32'h000F_FFFF) | (imm << 20);
                r.err  = (v < -2048) || (v > 2047);
            end
            3'd1: begin
                r.word = (base & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
                r.err  = (v < -2048) || (v > 2047);
            end
            3'd2: begin
                r.word = (base & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31)
                       | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
                       | (((imm >> 11) & 32'h1) << 7);
                r.err  = (v < -4096) || (v > 4094) || (imm[0] == 1'b1);
            end
            3'd3: begin
                r.word = (imm & 32'hFFFF_F000) | (base & 32'h0000_0FFF);
                r.err  = (imm & 32'h0000_0FFF) != 32'h0;
            end
            3'd4: begin
                r.word = (base & 32'h0000_0FFF) | (((imm >> 20) & 32'h1) << 31)
                       | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
                       | (imm & 32'h000F_F000);
                r.err  = (v < -1048576) || (v > 1048574) || (imm[0] == 1'b1);
            end
            default: begin
                r.word = base;
                r.err  = 1'b1;
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rand_imm();
        logic [31:0] r;
        logic [31:0] edges [12];
        edges = '{32'hFFFF_F800, 32'h0000_07FF, 32'h0000_0800, 32'hFFFF_F7FF,
                  32'hFFFF_F000, 32'h0000_0FFE, 32'h0000_1000, 32'hFFF0_0000,
                  32'h000F_FFFE, 32'h0010_0000, 32'hFFEF_FFFE, 32'h0000_0000};
        r = $urandom();
        case ($urandom_range(0, 5))
            0: return r;
            1: return edges[$urandom_range(0, 11)];
            2: return {{19{r[12]}}, r[12:0]};
            3: return r & 32'hFFFF_F000;
            4: return {{11{r[20]}}, r[20:1], 1'b0};
            default: return edges[$urandom_range(0, 11)] ^ 32'h1;
        endcase
    endfunction

    // Compare process: checks handshake, latency, data, hold stability and error count each cycle.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            model_cnt = 0;
            prev_hold = 1'b0;
        end else begin
            chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
            exp_ov = (q.size() > 0) && ((cyc - q[0].acc) >= 2);
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            if (out_valid && q.size() > 0) begin
                chk("instr_out", instr_out, q[0].word);
                chk("out_err", 32'(out_err), 32'(q[0].err));
            end
            if (prev_hold) begin
                chk("hold_word", instr_out, prev_word);
                chk("hold_err", 32'(out_err), 32'(prev_err));
            end
            chk("err_count", 32'(err_count), 32'(model_cnt));
            if (out_valid && out_ready && q.size() > 0) begin
                if (err_clr)
                    model_cnt = 0;
                else if (q[0].err && model_cnt != 65535)
                    model_cnt++;
                last_word = instr_out;
                last_err  = out_err;
                handoffs++;
                void'(q.pop_front());
            end else if (err_clr) begin
                model_cnt = 0;
            end
            prev_hold = out_valid && !out_ready;
            prev_word = instr_out;
            prev_err  = out_err;
            if (in_valid && in_ready) begin
                e     = model(imm_type, imm_val, base_instr);
                e.acc = cyc;
                q.push_back(e);
                accepted++;
            end
        end
    end

    // Random backpressure and occasional counter clears during the random phase.
    always @(posedge clk) begin
        if (rand_mode) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 31) == 0);
        end
    end

    // Present one request from posedge+1 and return just after the edge that accepts it.
    task automatic send(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] base);
        int guard;
        guard      = 0;
        imm_type   = t;
        imm_val    = imm;
        base_instr = base;
        in_valid   = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=stalled required=accept");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_handoffs(input int target);
        int guard;
        guard = 0;
        while (handoffs < target && guard < 1000) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (handoffs < target) begin
            checks++;
            failures++;
            $display("FAIL handoff_timeout actual=%0d required=%0d", handoffs, target);
        end
    endtask

    task automatic direct(input string name, input logic [2:0] t, input logic [31:0] imm,
                          input logic [31:0] base, input logic [31:0] xw, input logic xe);
        int h;
        h = handoffs;
        send(t, imm, base);
        wait_handoffs(h + 1);
        chk({name, "_word"}, last_word, xw);
        chk({name, "_err"}, 32'(last_err), 32'(xe));
    endtask

    initial begin
        exp_t m;
        int   h;
        int   guard;
        rst        = 1'b1;
        in_valid   = 1'b0;
        imm_type   = '0;
        imm_val    = '0;
        base_instr = '0;
        out_ready  = 1'b1;
        err_clr    = 1'b0;

        // Pin the reference model with hand-computed encodings.
        m = model(3'd0, 32'hFFFF_FFFF, 32'h13); chk("m_i_neg1", m.word, 32'hFFF0_0013); chk("m_i_neg1_err", 32'(m.err), 0);
        m = model(3'd2, 32'hFFFF_FFFE, 32'h63); chk("m_b_neg2", m.word, 32'hFE00_0FE3); chk("m_b_neg2_err", 32'(m.err), 0);
        m = model(3'd2, 32'h0000_0FFF, 32'h63); chk("m_b_odd", m.word, 32'h7E00_0FE3); chk("m_b_odd_err", 32'(m.err), 1);
        m = model(3'd1, 32'hFFFF_FFFC, 32'h23); chk("m_s_neg4", m.word, 32'hFE00_0E23);
        m = model(3'd4, 32'hFFFF_FFFE, 32'h6F); chk("m_j_neg2", m.word, 32'hFFFF_F06F);
        m = model(3'd3, 32'h1234_5001, 32'h37); chk("m_u_low", m.word, 32'h1234_5037); chk("m_u_low_err", 32'(m.err), 1);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_instr_out", instr_out, 0);
        chk("reset_err_count", 32'(err_count), 0);

        // Directed encodings with literal expectations.
        direct("i_neg1",  3'd0, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
        direct("b_neg2",  3'd2, 32'hFFFF_FFFE, 32'h0000_0063, 32'hFE00_0FE3, 1'b0);
        direct("b_odd",   3'd2, 32'h0000_0FFF, 32'h0000_0063, 32'h7E00_0FE3, 1'b1);
        chk("err_count_one", 32'(err_count), 1);
        direct("u_ok",    3'd3, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0);
        direct("u_low",   3'd3, 32'h1234_5001, 32'h0000_0037, 32'h1234_5037, 1'b1);
        direct("i_2048",  3'd0, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1);
        direct("illegal", 3'd6, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        chk("err_count_four", 32'(err_count), 4);

        // Backpressure: four requests against a stalled output.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        h = accepted;
        fork
            begin
                send(3'd0, 32'h0000_0001, 32'h13);
                send(3'd1, 32'h0000_0002, 32'h23);
                send(3'd2, 32'h0000_0004, 32'h63);
                send(3'd4, 32'h0000_0008, 32'h6F);
            end
        join_none
        repeat (6) @(posedge clk);
        #2;
        chk("bp_accepted", 32'(accepted - h), 2);
        chk("bp_in_ready", 32'(in_ready), 0);
        h = handoffs;
        out_ready = 1'b1;
        wait fork;
        wait_handoffs(h + 4);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_handoffs", 32'(handoffs - h), 4);

        // Reset with both stages full.
        out_ready = 1'b0;
        send(3'd0, 32'h0000_0800, 32'h13);
        send(3'd2, 32'h0000_0002, 32'h63);
        repeat (2) @(posedge clk);
        #1;
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_out_valid", 32'(out_valid), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_err_count", 32'(err_count), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        out_ready = 1'b1;

        // Clear coinciding with an errored handoff.
        direct("pre_clr", 3'd0, 32'h0000_0800, 32'h13, 32'h8000_0013, 1'b1);
        chk("pre_clr_count", 32'(err_count), 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(3'd0, 32'hFFFF_F000, 32'h13);
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("clr_setup_valid", 32'(out_valid), 1);
        err_clr   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("clr_wins", 32'(err_count), 0);

        // Random phase.
        rand_mode = 1;
        for (int i = 0; i < 300; i++) begin
            send(3'($urandom_range(0, 7)), rand_imm(), $urandom());
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_mode = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        guard = 0;
        while (q.size() > 0 && guard < 100) begin
            @(posedge clk);
            #2;
            guard++;
        end
        repeat (2) @(posedge clk);
        #2;
        chk("drain_empty", 32'(q.size()), 0);
        chk("drain_out_valid", 32'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
